// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low key matrix scanner with frame-based debounce.
// One column is driven low per SCAN_DIV cycles. Each completed four-column
// frame is classified as no key, one key or several keys, and the debounce
// FSM steps once per frame.
// Optional entry buffer: define ENTRY_BUF_EN to build the eight-digit BCD
// shift register on the digits output. When it is not defined, digits is tied to 0.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 256,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  col,
    input  logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic        multi_key,
    output logic [31:0] digits
);

    localparam int unsigned DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_N    = 4'(DEBOUNCE_SCANS);
    localparam logic [1:0]  COL_LAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_e;

    // Row synchronizer
    logic [3:0]       row_meta_q, row_meta_d;
    logic [3:0]       row_sync_q, row_sync_d;

    // Column scan timing
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [15:0]      map_q, map_d;

    // Debounce FSM and key outputs
    state_e           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             multi_q, multi_d;

    // Frame classification helpers
    logic             col_end;
    logic             frame_end;
    logic [15:0]      map_cur;
    logic [4:0]       key_cnt;
    logic [3:0]       key_idx;
    logic             cls_none;
    logic             cls_single;
    logic             cls_multi;

    // Two-stage synchronizer for the asynchronous row inputs
    always_comb begin
        row_meta_d = row;
        row_sync_d = row_meta_q;
    end

    // Column divider: advance the driven column after SCAN_DIV cycles
    always_comb begin
        col_end   = (div_q == DIV_LAST);
        frame_end = col_end && (col_idx_q == COL_LAST);
        div_d     = col_end ? '0 : div_q + DIV_W'(1);
        col_idx_d = col_end ? col_idx_q + 2'd1 : col_idx_q;
        col_d     = ~(4'b0001 << col_idx_d);
    end

    // Frame map with the active column's sample merged in (1 = key down)
    always_comb begin
        map_cur = map_q;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (2'(c) == col_idx_q) begin
                    map_cur[4*r+c] = ~row_sync_q[r];
                end
            end
        end
        map_d = col_end ? map_cur : map_q;
    end

    // Count keys in the frame and locate the (last) pressed one
    always_comb begin
        key_cnt = 5'd0;
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (map_cur[i]) begin
                key_cnt = key_cnt + 5'd1;
                key_idx = 4'(i);
            end
        end
        cls_none   = (key_cnt == 5'd0);
        cls_single = (key_cnt == 5'd1);
        cls_multi  = (key_cnt > 5'd1);
    end

    // Debounce FSM: evaluated once per frame end, outputs registered
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        multi_d     = multi_q;

        if (frame_end) begin
            multi_d = cls_multi;
            unique case (state_q)
                ST_IDLE: begin
                    if (cls_single) begin
                        cand_d = key_idx;
                        cnt_d  = 4'd1;
                        if (DEB_N <= 4'd1) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = key_idx;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end

                ST_DEBOUNCE: begin
                    if (cls_single && (key_idx == cand_q)) begin
                        cnt_d = cnt_q + 4'd1;
                        if ((cnt_q + 4'd1) >= DEB_N) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end
                    end else if (cls_single) begin
                        // A different single key restarts the count on it
                        cand_d = key_idx;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end

                ST_PRESSED: begin
                    if (cls_none) begin
                        cnt_d = 4'd1;
                        if (DEB_N <= 4'd1) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (cls_none) begin
                        cnt_d = cnt_q + 4'd1;
                        if ((cnt_q + 4'd1) >= DEB_N) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                        end
                    end else begin
                        // Key came back before release settled: no new event
                        state_d = ST_PRESSED;
                        cnt_d   = 4'd0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Scanner, synchronizer and FSM registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            map_q       <= 16'h0000;
            state_q     <= ST_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            map_q       <= map_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            multi_q     <= multi_d;
        end
    end

`ifdef ENTRY_BUF_EN
    logic [31:0] digits_q, digits_d;

    // Entry buffer: digits shift in, B deletes the newest, C clears
    always_comb begin
        digits_d = digits_q;
        if (key_valid_q) begin
            if (key_code_q <= 4'h9) begin
                digits_d = {digits_q[27:0], key_code_q};
            end else if (key_code_q == 4'hB) begin
                digits_d = {4'h0, digits_q[31:4]};
            end else if (key_code_q == 4'hC) begin
                digits_d = 32'h0000_0000;
            end
        end
    end

    // Entry buffer register
    always_ff @(posedge clk) begin
        if (!rst) begin
            digits_q <= 32'h0000_0000;
        end else begin
            digits_q <= digits_d;
        end
    end

    assign digits = digits_q;
`else
    assign digits = 32'h0000_0000;
`endif

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives row from col, and a
// frame-level reference model (run lengths of identical frames) predicts
// every output on every cycle. Build with ENTRY_BUF_EN to exercise digits.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;
    localparam int unsigned FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        multi_key;
    logic [31:0] digits;

    logic [15:0] keys;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Reference model state (frame level)
    bit          m_held;
    int          m_run_key;
    int          m_run_len;
    int          m_rel_len;
    logic [3:0]  m_code;
    bit          m_valid;
    bit          m_multi;
    logic [31:0] m_digits;
    logic [31:0] m_digits_pend;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .row      (row),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .multi_key(multi_key),
        .digits   (digits)
    );

    always #5 clk = ~clk;

    // Key matrix: a row reads low when a pressed key sits on the driven column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col[c] == 1'b0 && keys[4*r+c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] buf_apply(input logic [31:0] d, input logic [3:0] k);
`ifdef ENTRY_BUF_EN
        if (k <= 4'd9)  return (d * 32'd16) + 32'(k);
        if (k == 4'hB)  return d / 32'd16;
        if (k == 4'hC)  return 32'd0;
        return d;
`else
        return 32'd0 + 32'(d & 32'd0) + 32'(k & 4'd0);
`endif
    endfunction

    function automatic logic [31:0] exp_const(input logic [31:0] v);
`ifdef ENTRY_BUF_EN
        return v;
`else
        return 32'd0 + (v & 32'd0);
`endif
    endfunction

    task automatic model_reset();
        m_held = 0; m_run_key = 0; m_run_len = 0; m_rel_len = 0;
        m_code = 4'd0; m_valid = 0; m_multi = 0;
        m_digits = 32'd0; m_digits_pend = 32'd0;
    endtask

    // Apply one completed frame of the pressed-key set to the model
    task automatic model_frame(input logic [15:0] mask);
        int n;
        int idx;
        n = $countones(mask);
        idx = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
        m_valid = 0;
        m_multi = (n > 1);
        m_digits_pend = m_digits;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run_len > 0 && m_run_key == idx) m_run_len++;
                else begin
                    m_run_key = idx;
                    m_run_len = 1;
                end
                if (m_run_len >= int'(DEB)) begin
                    m_held = 1; m_valid = 1; m_code = 4'(idx);
                    m_run_len = 0; m_rel_len = 0;
                    m_digits_pend = buf_apply(m_digits, 4'(idx));
                end
            end else begin
                m_run_len = 0;
            end
        end else begin
            if (n == 0) begin
                m_rel_len++;
                if (m_rel_len >= int'(DEB)) begin
                    m_held = 0; m_rel_len = 0; m_run_len = 0;
                end
            end else begin
                m_rel_len = 0;
            end
        end
    endtask

    // Compare all outputs at position i (0..FRAME-1) of the current frame
    task automatic check_cycle(input int i);
        logic [3:0] ec;
        ec = 4'hF;
        ec[i / int'(SCAN_DIV)] = 1'b0;
        check("col", 32'(col), 32'(ec));
        check("key_valid", 32'(key_valid), 32'(m_valid));
        check("key_held", 32'(key_held), 32'(m_held));
        check("multi_key", 32'(multi_key), 32'(m_multi));
        check("key_code", 32'(key_code), 32'(m_code));
        check("digits", digits, m_digits);
    endtask

    // Entered at the negedge of the first cycle of a frame; returns at the next one
    task automatic run_frame(input logic [15:0] mask);
        keys = mask;
        check_cycle(0);
        if (key_valid) pulses++;
        m_valid = 0;
        m_digits = m_digits_pend;
        for (int i = 1; i < int'(FRAME); i++) begin
            @(negedge clk);
            check_cycle(i);
        end
        @(negedge clk);
        model_frame(mask);
    endtask

    task automatic press(input int code);
        repeat (DEB) run_frame(16'(1 << code));
        repeat (DEB) run_frame(16'h0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        logic [15:0] prev;
        int a;
        int b;
        int sel;

        keys = 16'h0000;
        rst  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col", 32'(col), 32'h0000000E);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        check("rst_multi", 32'(multi_key), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_digits", digits, 32'd0);
        rst = 1'b1;

        // Idle scanning
        repeat (2) run_frame(16'h0000);

        // Single key r1c2 held 5 frames, then released
        p0 = pulses;
        repeat (5) run_frame(16'h0040);
        repeat (3) run_frame(16'h0000);
        check("t2_pulses", 32'(pulses - p0), 32'd1);
        check("t2_code", 32'(key_code), 32'd6);
        check("t2_held", 32'(key_held), 32'd0);

        // Bouncing key r0c1: never stable for two frames
        p0 = pulses;
        for (int f = 0; f < 8; f++) run_frame((f % 2 == 0) ? 16'h0002 : 16'h0000);
        check("t3_pulses", 32'(pulses - p0), 32'd0);
        check("t3_held", 32'(key_held), 32'd0);

        // Two keys at once
        p0 = pulses;
        run_frame(16'h8001);
        check("t4_multi_on", 32'(multi_key), 32'd1);
        repeat (3) run_frame(16'h8001);
        run_frame(16'h0000);
        check("t4_multi_off", 32'(multi_key), 32'd0);
        check("t4_pulses", 32'(pulses - p0), 32'd0);
        run_frame(16'h0000);

        // Entry buffer sequence
        press(1); press(2); press(3);
        check("t5_123", digits, exp_const(32'h00000123));
        press(11);
        check("t5_back", digits, exp_const(32'h00000012));
        press(12);
        check("t5_clear", digits, exp_const(32'h00000000));
        repeat (9) press(9);
        check("t5_nines", digits, exp_const(32'h99999999));

        // Reset mid-frame with r2c0 held
        repeat (3) run_frame(16'h0100);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_col", 32'(col), 32'h0000000E);
            check("t6_valid", 32'(key_valid), 32'd0);
            check("t6_held", 32'(key_held), 32'd0);
            check("t6_code", 32'(key_code), 32'd0);
            check("t6_digits", digits, 32'd0);
        end
        rst = 1'b1;
        model_reset();
        p0 = pulses;
        repeat (3) run_frame(16'h0100);
        check("t6_pulses", 32'(pulses - p0), 32'd1);
        check("t6_code8", 32'(key_code), 32'd8);
        repeat (2) run_frame(16'h0000);

        // Randomized frames
        prev = 16'h0010;
        for (int f = 0; f < 60; f++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
                keys = prev;
            end else if (sel < 6) begin
                keys = 16'h0000;
            end else if (sel < 8) begin
                keys = 16'(1 << $urandom_range(0, 15));
                prev = keys;
            end else begin
                a = int'($urandom_range(0, 15));
                b = (a + int'($urandom_range(1, 15))) % 16;
                keys = 16'(1 << a) | 16'(1 << b);
            end
            run_frame(keys);
        end
        check_cycle(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 active-low key matrix. Drives one column low at a time, samples the rows, and debounces across whole scan frames. Emits a single-cycle key event with a hex code. Sits on the input side of the board I/O, opposite the seven-segment display path. Its optional entry buffer produces eight BCD nibbles that feed the display driver directly.

Parameters:
SCAN_DIV, 256, clk cycles each column is driven; minimum 4.
DEBOUNCE_SCANS, 4, consecutive identical frames required to accept a press or a release; minimum 1, maximum 15.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
col  output  4  column drive, active-low one-hot
row  input  4  row sense, active-low, externally pulled up, asynchronous
key_code  output  4  code of last accepted key = 4*row_index + col_index
key_valid  output  1  one-cycle pulse when a press is accepted
key_held  output  1  high from acceptance until release is accepted
multi_key  output  1  high while the last evaluated frame saw more than one key
digits  output  32  entry buffer; BCD1 = digits[3:0] ... BCD8 = digits[31:28]

Behaviour:
- Reset (rst=0 at a clk edge): col=4'b1110, column index 0, cycle counter 0, FSM=IDLE, key_code=0, key_valid=0, key_held=0, multi_key=0, digits=0, synchronizers cleared. Reset mid-operation aborts any debounce. A key still pressed after reset is treated as a new press.
- row passes through a 2-FF synchronizer before use.
- Column timing:
  - Counter runs 0..SCAN_DIV-1.
  - On the count==SCAN_DIV-1 cycle, the synced row is captured into a 16-bit frame map at bits [4*r+c], and the column advances (0->1->2->3->0).
  - col[i]=0 only for the active column.
  - Frame length = 4*SCAN_DIV cycles.
- Frame end (capture of column 3): the frame is classified as NONE (0 keys), SINGLE(code) (exactly 1 key), or MULTI (>1 key). multi_key updates on the following cycle and holds until the next frame end.
- FSM, evaluated once per frame end, with frame counter cnt (4 bits):
  - IDLE: SINGLE(k) -> DEBOUNCE, cand=k, cnt=1. Otherwise stay.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1.
    - When cnt reaches DEBOUNCE_SCANS -> PRESSED, key_code=cand, key_valid=1 for exactly one cycle, key_held=1.
    - SINGLE(other) -> restart with cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED: NONE -> RELEASE, cnt=1. SINGLE or MULTI -> stay. Key changes while held produce no new event.
  - RELEASE:
    - NONE -> cnt+1. At DEBOUNCE_SCANS -> IDLE, key_held=0.
    - Any key -> PRESSED with no new key_valid.
- Immediate acceptance: with DEBOUNCE_SCANS=1, a SINGLE frame in IDLE goes directly to PRESSED and pulses key_valid. The same applies to release.
- Latency: key_valid rises 1 cycle after the frame end of the DEBOUNCE_SCANS-th consecutive SINGLE frame.
- key_code holds its value until the next accepted press.
- key_valid never asserts on consecutive cycles.

Optional Feature:
Macro ENTRY_BUF_EN.
- Defined: on each key_valid cycle, digits updates on the next edge according to key_code:
  - 0x0-0x9: digits <= {digits[27:0], key_code}.
  - 0xB (backspace): digits <= {4'h0, digits[31:4]}.
  - 0xC (clear): digits <= 0.
  - All other codes: digits unchanged.
  - The oldest digit falls off the top when the buffer is full.
- Undefined: digits is constant 0 and no buffer logic is synthesized.

Test Plan:
Bench model: row[r]=0 iff col[c]=0 and key(r,c) is pressed. Use SCAN_DIV=4, DEBOUNCE_SCANS=2.
1. Reset, no keys -> col sequence 1110,1101,1011,0111, each for 4 cycles and repeating. key_valid, key_held, multi_key and digits all 0.
2. Hold key r1c2 for 5 frames, then release -> exactly one key_valid pulse with key_code=6, arriving 1 cycle after the 2nd frame end. key_held=1 until 2 NONE frames after release, then 0.
3. Key r0c1 alternates pressed/released every frame for 8 frames -> no key_valid; key_held stays 0.
4. Press r0c0 and r3c3 together for 4 frames -> multi_key=1 after the first frame end; no key_valid. Release both -> multi_key=0 after the next frame end.
5. ENTRY_BUF_EN defined, press and release 1, 2, 3 -> digits=32'h00000123. Then press B -> 32'h00000012. Then press C -> 0. Then press 9 nine times -> 32'h99999999.
6. Key r2c0 held, then rst=0 for 3 cycles mid-frame -> all outputs 0 and col=1110. Key still held after reset -> one new key_valid with key_code=8 after 2 frames.
